// File: rtl/irq_entry_sequencer.sv
// Machine-mode interrupt entry sequencer: waits for a safe EXE point, pulses flush/CSR strobes, redirects to mtvec.
// Optional: define IRQ_VECTORED_EN for vectored trap targets (mtvec[1:0]==2'b01).
module irq_entry_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MRET_HOLDOFF = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            irq_pending,
  input  logic [4:0]      irq_cause,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] exe_pc,
  input  logic            exe_valid,
  input  logic            stall_pipl,
  input  logic            load_hazard,
  input  logic            branch_hazard,
  input  logic            mret_type,
  output logic            interrupt,
  output logic            irq_taken,
  output logic [XLEN-1:0] epc,
  output logic [4:0]      cause,
  output logic            trap_pc_valid,
  output logic [XLEN-1:0] trap_pc,
  output logic            irq_busy
);

  localparam int unsigned     CW        = $clog2(MRET_HOLDOFF + 1);
  localparam logic [CW-1:0]   HOLD_LOAD = CW'(MRET_HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SAFE,
    S_TAKE,
    S_REDIRECT,
    S_HOLDOFF
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_safe;
  logic            w_capture;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_pc;
  logic [XLEN-1:0] r_epc;
  logic [4:0]      r_cause;
  logic [XLEN-1:0] r_trap_pc;

  assign w_safe = exe_valid & ~stall_pipl & ~load_hazard & ~branch_hazard & ~mret_type;
  assign w_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef IRQ_VECTORED_EN
  assign w_trap_pc = (mtvec[1:0] == 2'b01) ? (w_base + XLEN'({irq_cause, 2'b00})) : w_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^mtvec[1:0];
  assign w_trap_pc     = w_base;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mret_type) begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = HOLD_LOAD;
        end else if (irq_pending) begin
          w_state_nxt = S_WAIT_SAFE;
        end
      end
      S_WAIT_SAFE: begin
        if (!irq_pending) begin
          w_state_nxt = S_IDLE;
        end else if (w_safe) begin
          w_state_nxt = S_TAKE;
          w_capture   = 1'b1;
        end
      end
      S_TAKE:     w_state_nxt = S_REDIRECT;
      S_REDIRECT: w_state_nxt = S_IDLE;
      S_HOLDOFF: begin
        // a fresh mret restarts the full window; pending interrupts are ignored here
        if (mret_type) begin
          w_cnt_nxt = HOLD_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // trap target is latched with epc/cause so it stays stable through TAKE and REDIRECT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_epc     <= '0;
      r_cause   <= '0;
      r_trap_pc <= '0;
    end else if (w_capture) begin
      r_epc     <= exe_pc;
      r_cause   <= irq_cause;
      r_trap_pc <= w_trap_pc;
    end
  end

  assign interrupt     = (r_state == S_TAKE);
  assign irq_taken     = (r_state == S_TAKE);
  assign trap_pc_valid = (r_state == S_REDIRECT);
  assign irq_busy      = (r_state != S_IDLE);
  assign epc           = r_epc;
  assign cause         = r_cause;
  assign trap_pc       = r_trap_pc;

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Self-checking bench for irq_entry_sequencer: per-cycle behavioural model plus directed literal checks.
module tb_irq_entry_sequencer;

  localparam int XLEN = 32;
  localparam int HO   = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            irq_pending = 1'b0;
  logic [4:0]      irq_cause = '0;
  logic [XLEN-1:0] mtvec = '0;
  logic [XLEN-1:0] exe_pc = '0;
  logic            exe_valid = 1'b0;
  logic            stall_pipl = 1'b0;
  logic            load_hazard = 1'b0;
  logic            branch_hazard = 1'b0;
  logic            mret_type = 1'b0;
  logic            interrupt, irq_taken, trap_pc_valid, irq_busy;
  logic [XLEN-1:0] epc, trap_pc;
  logic [4:0]      cause;

  irq_entry_sequencer #(.XLEN(XLEN), .MRET_HOLDOFF(HO)) dut (
    .clk(clk), .reset_n(reset_n), .irq_pending(irq_pending), .irq_cause(irq_cause),
    .mtvec(mtvec), .exe_pc(exe_pc), .exe_valid(exe_valid), .stall_pipl(stall_pipl),
    .load_hazard(load_hazard), .branch_hazard(branch_hazard), .mret_type(mret_type),
    .interrupt(interrupt), .irq_taken(irq_taken), .epc(epc), .cause(cause),
    .trap_pc_valid(trap_pc_valid), .trap_pc(trap_pc), .irq_busy(irq_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: entry progress as a remaining hold-off count plus flags for the entry steps.
  int              m_hold  = 0;
  bit              m_wait  = 0;
  bit              m_take  = 0;
  bit              m_redir = 0;
  logic [XLEN-1:0] m_epc   = '0;
  logic [XLEN-1:0] m_tpc   = '0;
  logic [4:0]      m_cause = '0;

  function automatic logic [XLEN-1:0] exp_tpc(input logic [XLEN-1:0] tv, input logic [4:0] c);
    logic [XLEN-1:0] base;
    base = tv & ~32'h3;
`ifdef IRQ_VECTORED_EN
    if (tv[1:0] == 2'b01) return base + (32'(c) * 32'd4);
`endif
    return base;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hold <= 0; m_wait <= 0; m_take <= 0; m_redir <= 0;
      m_epc <= '0; m_tpc <= '0; m_cause <= '0;
    end else if (m_take) begin
      m_take <= 0; m_redir <= 1;
    end else if (m_redir) begin
      m_redir <= 0;
    end else if (m_hold > 0) begin
      m_hold <= mret_type ? HO : m_hold - 1;
    end else if (m_wait) begin
      if (!irq_pending) m_wait <= 0;
      else if (exe_valid && !stall_pipl && !load_hazard && !branch_hazard && !mret_type) begin
        m_wait <= 0; m_take <= 1;
        m_epc <= exe_pc; m_cause <= irq_cause; m_tpc <= exp_tpc(mtvec, irq_cause);
      end
    end else if (mret_type) begin
      m_hold <= HO;
    end else if (irq_pending) begin
      m_wait <= 1;
    end
  end

  always @(negedge clk) begin
    chk("m_interrupt", interrupt, m_take);
    chk("m_irq_taken", irq_taken, m_take);
    chk("m_trap_pc_valid", trap_pc_valid, m_redir);
    chk("m_irq_busy", irq_busy, (m_hold > 0) || m_wait || m_take || m_redir);
    chk("m_epc", epc, m_epc);
    chk("m_cause", cause, m_cause);
    chk("m_trap_pc", trap_pc, m_tpc);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_interrupt", interrupt, 0);
    chk("rst_irq_taken", irq_taken, 0);
    chk("rst_trap_pc_valid", trap_pc_valid, 0);
    chk("rst_irq_busy", irq_busy, 0);
    chk("rst_epc", epc, 0);
    chk("rst_cause", cause, 0);
    chk("rst_trap_pc", trap_pc, 0);
    @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;

    // basic entry
    irq_pending = 1; irq_cause = 7; exe_valid = 1; exe_pc = 32'h100; mtvec = 32'h800;
    tick; chk("basic_no_int_yet", interrupt, 0); chk("basic_busy", irq_busy, 1);
    tick; chk("basic_int", interrupt, 1); chk("basic_taken", irq_taken, 1);
    chk("basic_epc", epc, 32'h100); chk("basic_cause", cause, 7); chk("basic_tpc_take", trap_pc, 32'h800);
    irq_pending = 0;
    tick; chk("basic_redir", trap_pc_valid, 1); chk("basic_int_off", interrupt, 0);
    chk("basic_tpc", trap_pc, 32'h800);
    tick; chk("basic_idle", irq_busy, 0); chk("basic_redir_off", trap_pc_valid, 0);

    // hazard deferral
    irq_pending = 1; irq_cause = 3; load_hazard = 1; exe_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick; chk("haz_no_int", interrupt, 0);
      exe_pc = exe_pc + 32'h4;
    end
    load_hazard = 0;
    tick; chk("haz_int", interrupt, 1); chk("haz_epc", epc, 32'h20C); chk("haz_cause", cause, 3);
    irq_pending = 0;
    tick; tick; chk("haz_idle", irq_busy, 0);

    // withdrawal
    irq_pending = 1; stall_pipl = 1;
    tick; tick; chk("wd_wait_busy", irq_busy, 1); chk("wd_no_int", interrupt, 0);
    irq_pending = 0;
    tick; chk("wd_idle", irq_busy, 0);
    stall_pipl = 0;
    tick; chk("wd_no_taken", irq_taken, 0); chk("wd_no_int2", interrupt, 0);

    // mret hold-off with interrupt pending
    irq_pending = 1; mret_type = 1;
    tick; mret_type = 0; chk("ho_busy0", irq_busy, 1); chk("ho_no_int0", interrupt, 0);
    for (int i = 1; i < 4; i++) begin
      tick; chk("ho_busy", irq_busy, 1); chk("ho_no_int", interrupt, 0);
    end
    tick; chk("ho_end_idle", irq_busy, 0);
    tick; chk("ho_wait", irq_busy, 1); chk("ho_wait_no_int", interrupt, 0);
    tick; chk("ho_entry_int", interrupt, 1);
    irq_pending = 0;
    tick; tick; chk("ho_entry_idle", irq_busy, 0);

    // second mret at hold-off cycle 2 extends the window
    mret_type = 1;
    tick; mret_type = 0; chk("ho2_c1", irq_busy, 1);
    tick; chk("ho2_c2", irq_busy, 1);
    mret_type = 1;
    tick; mret_type = 0; chk("ho2_reload", irq_busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick; chk("ho2_ext", irq_busy, 1);
    end
    tick; chk("ho2_idle", irq_busy, 0);

    // vectored target
    mtvec = 32'h801; irq_cause = 11; exe_pc = 32'h400; irq_pending = 1;
    tick; tick; chk("vec_int", interrupt, 1);
    irq_pending = 0;
    tick; chk("vec_redir", trap_pc_valid, 1);
`ifdef IRQ_VECTORED_EN
    chk("vec_tpc", trap_pc, 32'h82C);
`else
    chk("vec_tpc", trap_pc, 32'h800);
`endif
    tick;

    // reset during TAKE
    mtvec = 32'h800; irq_cause = 5; exe_pc = 32'h300; irq_pending = 1;
    tick; tick; chk("rstm_int", interrupt, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rstm_interrupt", interrupt, 0); chk("rstm_taken", irq_taken, 0);
    chk("rstm_busy", irq_busy, 0); chk("rstm_epc", epc, 0);
    chk("rstm_cause", cause, 0); chk("rstm_tpc", trap_pc, 0);
    irq_pending = 0;
    @(posedge clk); #2 reset_n = 1'b1;
    tick; chk("rstm_no_redir1", trap_pc_valid, 0);
    tick; chk("rstm_no_redir2", trap_pc_valid, 0); chk("rstm_idle", irq_busy, 0);

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
